// File: rtl/ram_port_arbiter.sv
// Two-port arbiter for the single data-RAM port: picks a winner, runs one RAM access cycle,
// and for reads returns the RAM data to the winning port with a one-cycle valid pulse.
module ram_port_arbiter #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8,
   parameter bit          RR     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              ram_ena,
   output logic              ram_read,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

   state_e              state_q, state_d;
   logic                last_q, last_d;
   logic                owner_q, owner_d;
   logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic                ram_ena_q, ram_ena_d;
   logic                ram_read_q, ram_read_d;
   logic                ram_write_q, ram_write_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic                busy_q, busy_d;
   logic                win;

   // Under contention round-robin favours the port not granted last.
   always_comb begin
      if (req0 && req1) begin
         win = RR ? ~last_q : 1'b0;
      end else begin
         win = req1;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      ram_ena_d   = 1'b0;
      ram_read_d  = 1'b0;
      ram_write_d = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      busy_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               state_d     = StAcc;
               last_d      = win;
               owner_d     = win;
               gnt0_d      = ~win;
               gnt1_d      = win;
               ram_ena_d   = 1'b1;
               ram_write_d = win ? we1 : we0;
               ram_read_d  = win ? ~we1 : ~we0;
               ram_addr_d  = win ? addr1 : addr0;
               ram_wdata_d = win ? wdata1 : wdata0;
               busy_d      = 1'b1;
            end
         end
         StAcc: begin
            // ram_write_q holds the latched command for the access in flight.
            state_d = ram_write_q ? StIdle : StResp;
            busy_d  = ~ram_write_q;
         end
         StResp: begin
            state_d = StIdle;
            if (owner_q) begin
               rvalid1_d = 1'b1;
               rdata1_d  = ram_rdata;
            end else begin
               rvalid0_d = 1'b1;
               rdata0_d  = ram_rdata;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         ram_ena_q   <= 1'b0;
         ram_read_q  <= 1'b0;
         ram_write_q <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         ram_ena_q   <= ram_ena_d;
         ram_read_q  <= ram_read_d;
         ram_write_q <= ram_write_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign ram_ena   = ram_ena_q;
   assign ram_read  = ram_read_q;
   assign ram_write = ram_write_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign busy      = busy_q;
   assign owner     = owner_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a round-robin instance with a RAM model and a transaction-level
// reference model, plus a fixed-priority instance for the priority scenario.
module tb_ram_port_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   always #5 clk = ~clk;

   // Round-robin instance
   logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
   logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
   logic       gnt0, rvalid0, gnt1, rvalid1, ram_ena, ram_read, ram_write, busy, owner;
   logic [7:0] rdata0, rdata1, ram_addr, ram_wdata;
   logic [7:0] ram_rdata = 0;

   // Fixed-priority instance
   logic       f_req0 = 0, f_we0 = 0, f_req1 = 0, f_we1 = 0;
   logic [7:0] f_addr0 = 0, f_wdata0 = 0, f_addr1 = 0, f_wdata1 = 0;
   logic       f_gnt0, f_rvalid0, f_gnt1, f_rvalid1, f_ram_ena, f_ram_read, f_ram_write;
   logic       f_busy, f_owner;
   logic [7:0] f_rdata0, f_rdata1, f_ram_addr, f_ram_wdata;
   logic [7:0] f_ram_rdata = 0;

   ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RR(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .ram_ena(ram_ena), .ram_read(ram_read), .ram_write(ram_write),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .busy(busy), .owner(owner)
   );

   ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RR(1'b0)) dut_fixed (
      .clk(clk), .rst(rst),
      .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0),
      .gnt0(f_gnt0), .rvalid0(f_rvalid0), .rdata0(f_rdata0),
      .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1),
      .gnt1(f_gnt1), .rvalid1(f_rvalid1), .rdata1(f_rdata1),
      .ram_ena(f_ram_ena), .ram_read(f_ram_read), .ram_write(f_ram_write),
      .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_rdata(f_ram_rdata),
      .busy(f_busy), .owner(f_owner)
   );

   // RAM models: read data valid in the cycle after the read strobe.
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
      end else if (ram_ena && ram_write) begin
         mem[ram_addr] <= ram_wdata;
      end
      if (ram_ena && ram_read) ram_rdata <= mem[ram_addr];
   end

   always @(posedge clk) begin
      if (f_ram_ena && f_ram_read) f_ram_rdata <= f_ram_addr ^ 8'h5A;
   end

   // Reference model state
   logic [7:0] ref_mem [256];
   logic       last_ref;
   logic [7:0] exp_rdata0, exp_rdata1;
   int         checks = 0;
   int         errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
      last_ref   = 1'b1;
      exp_rdata0 = 8'h00;
      exp_rdata1 = 8'h00;
   endtask

   task automatic apply_reset(input int cycles);
      rst = 1'b1;
      req0 = 0; req1 = 0; f_req0 = 0; f_req1 = 0;
      repeat (cycles) tick();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset(3);
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({gnt0, gnt1, rvalid0, rvalid1, ram_ena, ram_read, ram_write, busy, owner} !== 9'b0)
         begin
            errors++;
            $display("FAIL reset_ctrl cycle %0d got %b exp 000000000", c,
                     {gnt0, gnt1, rvalid0, rvalid1, ram_ena, ram_read, ram_write, busy, owner});
         end
      end
      checks++;
      if ({ram_addr, ram_wdata, rdata0, rdata1} !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got %h exp 00000000", {ram_addr, ram_wdata, rdata0, rdata1});
      end
   endtask

   task automatic test_write_read();
      req0 = 1; we0 = 1; addr0 = 8'h12; wdata0 = 8'hA5;
      tick();
      checks++;
      if ({gnt0, gnt1, ram_ena, ram_write, ram_read, busy, owner} !== 7'b1011010) begin
         errors++;
         $display("FAIL wr_acc got %b exp 1011010",
                  {gnt0, gnt1, ram_ena, ram_write, ram_read, busy, owner});
      end
      checks++;
      if ({ram_addr, ram_wdata} !== 16'h12A5) begin
         errors++;
         $display("FAIL wr_addr_data got %h exp 12a5", {ram_addr, ram_wdata});
      end
      req0 = 0;
      tick();
      checks++;
      if ({gnt0, ram_ena, ram_write, busy} !== 4'b0) begin
         errors++;
         $display("FAIL wr_idle got %b exp 0000", {gnt0, ram_ena, ram_write, busy});
      end
      ref_mem[8'h12] = 8'hA5;
      last_ref = 1'b0;
      req1 = 1; we1 = 0; addr1 = 8'h12;
      tick();
      checks++;
      if ({gnt0, gnt1, ram_ena, ram_write, ram_read, owner} !== 6'b011011) begin
         errors++;
         $display("FAIL rd_acc got %b exp 011011", {gnt0, gnt1, ram_ena, ram_write, ram_read, owner});
      end
      req1 = 0;
      tick();
      checks++;
      if ({rvalid1, ram_ena, busy} !== 3'b001) begin
         errors++;
         $display("FAIL rd_resp got %b exp 001", {rvalid1, ram_ena, busy});
      end
      tick();
      last_ref = 1'b1;
      exp_rdata1 = 8'hA5;
      checks++;
      if ({rvalid0, rvalid1, busy, rdata1, rdata0} !== {3'b010, exp_rdata1, exp_rdata0}) begin
         errors++;
         $display("FAIL rd_data got %h exp %h", {rvalid0, rvalid1, busy, rdata1, rdata0},
                  {3'b010, exp_rdata1, exp_rdata0});
      end
   endtask

   task automatic test_round_robin();
      logic order [4];
      int   ng = 0, nr = 0;
      logic w;
      apply_reset(2);
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h20; addr1 = 8'h21;
      for (int cyc = 0; cyc < 40 && nr < 4; cyc++) begin
         tick();
         checks++;
         if (gnt0 && gnt1) begin
            errors++;
            $display("FAIL rr_excl cycle %0d got gnt0=1 gnt1=1 exp not both", cyc);
         end
         if ((gnt0 || gnt1) && ng < 4) begin
            order[ng] = gnt1;
            ng++;
            if (ng == 4) begin req0 = 0; req1 = 0; end
         end
         if ((rvalid0 || rvalid1) && nr < 4) begin
            checks++;
            if ({rvalid0, rvalid1} !== {~order[nr], order[nr]}) begin
               errors++;
               $display("FAIL rr_rvalid_port resp %0d got %b exp %b", nr, {rvalid0, rvalid1},
                        {~order[nr], order[nr]});
            end
            checks++;
            if ((order[nr] ? rdata1 : rdata0) !== ref_mem[order[nr] ? 8'h21 : 8'h20]) begin
               errors++;
               $display("FAIL rr_rdata resp %0d got %h exp %h", nr,
                        order[nr] ? rdata1 : rdata0, ref_mem[order[nr] ? 8'h21 : 8'h20]);
            end
            nr++;
         end
      end
      checks++;
      if (nr != 4) begin
         errors++;
         $display("FAIL rr_timeout got %0d responses exp 4", nr);
      end
      for (int i = 0; i < ng; i++) begin
         w = ~last_ref;
         last_ref = w;
         checks++;
         if (order[i] !== w) begin
            errors++;
            $display("FAIL rr_order grant %0d got port %0d exp port %0d", i, order[i], w);
         end
      end
      exp_rdata0 = ref_mem[8'h20];
      exp_rdata1 = ref_mem[8'h21];
   endtask

   task automatic test_fixed_priority();
      int   ng0 = 0, nv0 = 0;
      logic seen1 = 0;
      apply_reset(2);
      f_req0 = 1; f_req1 = 1; f_we0 = 0; f_we1 = 0; f_addr0 = 8'h30; f_addr1 = 8'h31;
      for (int cyc = 0; cyc < 60 && !seen1; cyc++) begin
         tick();
         if (f_gnt0) begin
            ng0++;
            if (ng0 == 4) f_req0 = 0;
         end
         if (f_rvalid0) begin
            nv0++;
            checks++;
            if (f_rdata0 !== 8'h6A) begin
               errors++;
               $display("FAIL fp_rdata0 got %h exp 6a", f_rdata0);
            end
         end
         checks++;
         if (f_rvalid1 !== 1'b0) begin
            errors++;
            $display("FAIL fp_rvalid1 cycle %0d got 1 exp 0", cyc);
         end
         if (f_gnt1) begin
            seen1 = 1;
            checks++;
            if (ng0 != 4 || nv0 != 4) begin
               errors++;
               $display("FAIL fp_gnt1_early got %0d grants %0d rvalids exp 4 4", ng0, nv0);
            end
         end
      end
      checks++;
      if (!seen1) begin
         errors++;
         $display("FAIL fp_gnt1_timeout got no gnt1 exp gnt1 after req0 drops");
      end
      f_req1 = 0;
      repeat (3) tick();
   endtask

   task automatic test_reset_in_resp();
      apply_reset(2);
      req0 = 1; we0 = 0; addr0 = 8'h40;
      tick();
      checks++;
      if ({gnt0, ram_read} !== 2'b11) begin
         errors++;
         $display("FAIL rir_acc got %b exp 11", {gnt0, ram_read});
      end
      req0 = 0;
      tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rir_resp_busy got %b exp 1", busy);
      end
      rst = 1;
      tick();
      checks++;
      if ({gnt0, gnt1, rvalid0, rvalid1, ram_ena, ram_read, ram_write, busy, owner, rdata0,
           ram_addr} !== 25'b0) begin
         errors++;
         $display("FAIL rir_outputs got %h exp 0", {gnt0, gnt1, rvalid0, rvalid1, ram_ena,
                  ram_read, ram_write, busy, owner, rdata0, ram_addr});
      end
      rst = 0;
      model_reset();
      tick();
      checks++;
      if (rvalid0 !== 1'b0) begin
         errors++;
         $display("FAIL rir_no_rvalid got %b exp 0", rvalid0);
      end
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr1 = 8'h41;
      tick();
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         errors++;
         $display("FAIL rir_contention got %b exp 10", {gnt0, gnt1});
      end
      req0 = 0; req1 = 0;
      last_ref = 1'b0;
      exp_rdata0 = ref_mem[8'h40];
      tick();
      tick();
      checks++;
      if ({rvalid0, rdata0} !== {1'b1, exp_rdata0}) begin
         errors++;
         $display("FAIL rir_read_after got %h exp %h", {rvalid0, rdata0}, {1'b1, exp_rdata0});
      end
   endtask

   task automatic test_back_to_back();
      int   ngr = 0, last_cyc = -1;
      logic prev_wr = 0;
      req0 = 1; we0 = 1; addr0 = 8'h60; wdata0 = 8'($urandom);
      for (int cyc = 0; cyc < 12; cyc++) begin
         tick();
         checks++;
         if (ram_write && prev_wr) begin
            errors++;
            $display("FAIL b2b_write_consec cycle %0d got 1 1 exp not both", cyc);
         end
         prev_wr = ram_write;
         if (gnt0) begin
            if (last_cyc >= 0) begin
               checks++;
               if (cyc - last_cyc != 2) begin
                  errors++;
                  $display("FAIL b2b_spacing got %0d exp 2", cyc - last_cyc);
               end
            end
            checks++;
            if ({ram_addr, ram_wdata} !== {addr0, wdata0}) begin
               errors++;
               $display("FAIL b2b_cmd got %h exp %h", {ram_addr, ram_wdata}, {addr0, wdata0});
            end
            ref_mem[addr0] = wdata0;
            last_ref = 1'b0;
            last_cyc = cyc;
            ngr++;
            addr0 = addr0 + 8'd1;
            wdata0 = 8'($urandom);
         end
      end
      req0 = 0;
      checks++;
      if (ngr != 6) begin
         errors++;
         $display("FAIL b2b_count got %0d exp 6", ngr);
      end
      tick();
   endtask

   task automatic test_random();
      logic       r0, r1, w, we;
      logic [7:0] a, d;
      for (int t = 0; t < 60; t++) begin
         r0 = 1'($urandom_range(0, 3) != 0);
         r1 = 1'($urandom_range(0, 3) != 0);
         req0 = r0; we0 = 1'($urandom); addr0 = 8'($urandom_range(0, 15)); wdata0 = 8'($urandom);
         req1 = r1; we1 = 1'($urandom); addr1 = 8'($urandom_range(0, 15)); wdata1 = 8'($urandom);
         if (!r0 && !r1) begin
            tick();
            checks++;
            if ({gnt0, gnt1, busy} !== 3'b0) begin
               errors++;
               $display("FAIL rnd_idle txn %0d got %b exp 000", t, {gnt0, gnt1, busy});
            end
            continue;
         end
         w  = (r0 && r1) ? ~last_ref : r1;
         last_ref = w;
         we = w ? we1 : we0;
         a  = w ? addr1 : addr0;
         d  = w ? wdata1 : wdata0;
         tick();
         checks++;
         if ({gnt0, gnt1, ram_ena, ram_write, ram_read, owner, ram_addr, ram_wdata} !==
             {~w, w, 1'b1, we, ~we, w, a, d}) begin
            errors++;
            $display("FAIL rnd_acc txn %0d got %h exp %h", t,
                     {gnt0, gnt1, ram_ena, ram_write, ram_read, owner, ram_addr, ram_wdata},
                     {~w, w, 1'b1, we, ~we, w, a, d});
         end
         req0 = 0; req1 = 0;
         if (we) begin
            ref_mem[a] = d;
            tick();
            checks++;
            if ({busy, ram_ena} !== 2'b00) begin
               errors++;
               $display("FAIL rnd_wr_done txn %0d got %b exp 00", t, {busy, ram_ena});
            end
         end else begin
            if (w) exp_rdata1 = ref_mem[a];
            else   exp_rdata0 = ref_mem[a];
            tick();
            tick();
            checks++;
            if ({rvalid0, rvalid1, rdata0, rdata1} !== {~w, w, exp_rdata0, exp_rdata1}) begin
               errors++;
               $display("FAIL rnd_rd txn %0d got %h exp %h", t, {rvalid0, rvalid1, rdata0, rdata1},
                        {~w, w, exp_rdata0, exp_rdata1});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_round_robin();
      test_fixed_priority();
      test_reset_in_resp();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
